// File: rtl/wb_bus_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_bus_arbiter_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT_I = 2'b01,
        ARB_GNT_D = 2'b10
    } arb_state_e;

    localparam logic [3:0] WB_SEL_WORD = 4'hF;
    localparam logic GNT_IS_I = 1'b0;
    localparam logic GNT_IS_D = 1'b1;
endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bus bundle: instruction/data master ports plus the shared slave-side port.
interface wb_bus_arbiter_if;
    logic        iwbs_cyc_i, iwbs_stb_i;
    logic [31:0] iwbs_addr_i, iwbs_dat_o;
    logic        iwbs_ack_o, iwbs_err_o;
    logic        dwbs_cyc_i, dwbs_stb_i, dwbs_we_i;
    logic [3:0]  dwbs_sel_i;
    logic [31:0] dwbs_addr_i, dwbs_dat_i, dwbs_dat_o;
    logic        dwbs_ack_o, dwbs_err_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_addr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;

    // Arbiter view: it is the slave of both core ports.
    modport slave (
        input  iwbs_cyc_i, iwbs_stb_i, iwbs_addr_i,
        output iwbs_dat_o, iwbs_ack_o, iwbs_err_o,
        input  dwbs_cyc_i, dwbs_stb_i, dwbs_we_i, dwbs_sel_i, dwbs_addr_i, dwbs_dat_i,
        output dwbs_dat_o, dwbs_ack_o, dwbs_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    // Environment view: core masters plus the downstream slave.
    modport master (
        output iwbs_cyc_i, iwbs_stb_i, iwbs_addr_i,
        input  iwbs_dat_o, iwbs_ack_o, iwbs_err_o,
        output dwbs_cyc_i, dwbs_stb_i, dwbs_we_i, dwbs_sel_i, dwbs_addr_i, dwbs_dat_i,
        input  dwbs_dat_o, dwbs_ack_o, dwbs_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/wb_bus_arbiter_bus_timeout.sv
// Saturating cycle counter that flags a granted transfer waiting too long for a response.
module bus_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    input  logic rsp_i,
    output logic hit_o
);
    localparam bit              ENABLE  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // A response landing on the deadline cycle wins over the timeout.
    assign hit_o = ENABLE && (cnt_q == HIT_VAL) && !rsp_i;
endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave port between the
// core's instruction and data masters, with bus-timeout abort.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    wb_bus_arbiter_if.slave bus
);
    arb_state_e state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       req_i, req_d, rsp, tmo_hit, tmo_clr, tmo_inc;

    assign req_i   = bus.iwbs_cyc_i & bus.iwbs_stb_i;
    assign req_d   = bus.dwbs_cyc_i & bus.dwbs_stb_i;
    assign rsp     = bus.wbm_ack_i | bus.wbm_err_i;
    assign tmo_inc = (state_q != ARB_IDLE) & ~rsp;

    assign bus.iwbs_dat_o = bus.wbm_dat_i;
    assign bus.dwbs_dat_o = bus.wbm_dat_i;

    bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_tmo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(tmo_clr),
        .inc_i(tmo_inc),
        .rsp_i(rsp),
        .hit_o(tmo_hit)
    );

    always_comb begin
        state_d        = state_q;
        last_gnt_d     = last_gnt_q;
        tmo_clr        = 1'b1;
        bus.wbm_cyc_o  = 1'b0;
        bus.wbm_stb_o  = 1'b0;
        bus.wbm_we_o   = 1'b0;
        bus.wbm_sel_o  = '0;
        bus.wbm_addr_o = '0;
        bus.wbm_dat_o  = '0;
        bus.iwbs_ack_o = 1'b0;
        bus.iwbs_err_o = 1'b0;
        bus.dwbs_ack_o = 1'b0;
        bus.dwbs_err_o = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // On contention the master that did not go last wins.
                if (req_i && req_d)
                    state_d = (last_gnt_q == GNT_IS_D) ? ARB_GNT_I : ARB_GNT_D;
                else if (req_i)
                    state_d = ARB_GNT_I;
                else if (req_d)
                    state_d = ARB_GNT_D;
            end
            ARB_GNT_I: begin
                tmo_clr        = 1'b0;
                bus.wbm_cyc_o  = bus.iwbs_cyc_i & ~tmo_hit;
                bus.wbm_stb_o  = bus.iwbs_stb_i & ~tmo_hit;
                bus.wbm_sel_o  = WB_SEL_WORD;
                bus.wbm_addr_o = bus.iwbs_addr_i;
                bus.iwbs_ack_o = bus.wbm_ack_i & ~bus.wbm_err_i;
                bus.iwbs_err_o = bus.wbm_err_i | tmo_hit;
                if (rsp || tmo_hit || !bus.iwbs_cyc_i) begin
                    state_d    = ARB_IDLE;
                    last_gnt_d = GNT_IS_I;
                    tmo_clr    = 1'b1;
                end
            end
            ARB_GNT_D: begin
                tmo_clr        = 1'b0;
                bus.wbm_cyc_o  = bus.dwbs_cyc_i & ~tmo_hit;
                bus.wbm_stb_o  = bus.dwbs_stb_i & ~tmo_hit;
                bus.wbm_we_o   = bus.dwbs_we_i;
                bus.wbm_sel_o  = bus.dwbs_sel_i;
                bus.wbm_addr_o = bus.dwbs_addr_i;
                bus.wbm_dat_o  = bus.dwbs_dat_i;
                bus.dwbs_ack_o = bus.wbm_ack_i & ~bus.wbm_err_i;
                bus.dwbs_err_o = bus.wbm_err_i | tmo_hit;
                if (rsp || tmo_hit || !bus.dwbs_cyc_i) begin
                    state_d    = ARB_IDLE;
                    last_gnt_d = GNT_IS_D;
                    tmo_clr    = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= GNT_IS_I;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: one instance with a short timeout, one with timeout disabled.
module tb_wb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   e1    = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter_if b0();
    wb_bus_arbiter_if b1();

    wb_bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
    wb_bus_arbiter #(.TIMEOUT_CYCLES(0), .CNT_W(8)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1));

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reqi(input logic on, input logic [31:0] a);
        b0.iwbs_cyc_i  = on;
        b0.iwbs_stb_i  = on;
        b0.iwbs_addr_i = a;
    endtask

    task automatic reqd(input logic on, input logic we, input logic [3:0] sel,
                        input logic [31:0] a, input logic [31:0] d);
        b0.dwbs_cyc_i  = on;
        b0.dwbs_stb_i  = on;
        b0.dwbs_we_i   = we;
        b0.dwbs_sel_i  = sel;
        b0.dwbs_addr_i = a;
        b0.dwbs_dat_i  = d;
    endtask

    initial begin
        reqi(1'b0, 32'h0);
        reqd(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        b0.wbm_dat_i = '0; b0.wbm_ack_i = 1'b0; b0.wbm_err_i = 1'b0;
        b1.iwbs_cyc_i = 1'b0; b1.iwbs_stb_i = 1'b0; b1.iwbs_addr_i = '0;
        b1.dwbs_cyc_i = 1'b0; b1.dwbs_stb_i = 1'b0; b1.dwbs_we_i = 1'b0;
        b1.dwbs_sel_i = '0; b1.dwbs_addr_i = '0; b1.dwbs_dat_i = '0;
        b1.wbm_dat_i = '0; b1.wbm_ack_i = 1'b0; b1.wbm_err_i = 1'b0;

        // Reset held two cycles while both masters request.
        reqi(1'b1, 32'h0000_1000);
        reqd(1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
        tick(); #1;
        ck("rst1_cyc", b0.wbm_cyc_o, 0);
        ck("rst1_rsp", {b0.iwbs_ack_o, b0.iwbs_err_o, b0.dwbs_ack_o, b0.dwbs_err_o}, 0);
        tick(); #1;
        ck("rst2_bus", {b0.wbm_cyc_o, b0.wbm_stb_o, b0.wbm_we_o, b0.wbm_sel_o}, 0);
        ck("rst2_addr", b0.wbm_addr_o, 0);
        ck("rst2_dat", b0.wbm_dat_o, 0);
        rst = 1'b1;
        #1 ck("arb_lat_cyc", b0.wbm_cyc_o, 0);
        tick(); #1;
        ck("first_d_cyc", b0.wbm_cyc_o, 1);
        ck("first_d_addr", b0.wbm_addr_o, 32'h0000_2000);
        b0.wbm_ack_i = 1'b1; b0.wbm_dat_i = 32'h55;
        #1;
        ck("first_d_ack", {b0.iwbs_ack_o, b0.dwbs_ack_o}, 2'b01);
        ck("first_d_dat", b0.dwbs_dat_o, 32'h55);
        tick();
        b0.wbm_ack_i = 1'b0;
        reqi(1'b0, 32'h0);
        reqd(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1 ck("bubble_cyc", b0.wbm_cyc_o, 0);

        // Instruction read, acked in the third granted cycle.
        reqi(1'b1, 32'h8000_0000);
        tick(); #1;
        ck("ird_cyc", {b0.wbm_cyc_o, b0.wbm_stb_o}, 2'b11);
        ck("ird_addr", b0.wbm_addr_o, 32'h8000_0000);
        ck("ird_we_sel", {b0.wbm_we_o, b0.wbm_sel_o}, 5'h0F);
        ck("ird_wdat", b0.wbm_dat_o, 0);
        ck("ird_ack_c1", b0.iwbs_ack_o, 0);
        tick(); #1 ck("ird_ack_c2", b0.iwbs_ack_o, 0);
        tick();
        b0.wbm_ack_i = 1'b1; b0.wbm_dat_i = 32'h0000_0013;
        #1;
        ck("ird_ack", {b0.iwbs_ack_o, b0.dwbs_ack_o}, 2'b10);
        ck("ird_dat", b0.iwbs_dat_o, 32'h13);
        tick();
        b0.wbm_ack_i = 1'b0;
        reqi(1'b0, 32'h0);
        #1;
        ck("ird_done_ack", b0.iwbs_ack_o, 0);
        ck("ird_done_cyc", b0.wbm_cyc_o, 0);

        // Continuous contention: D,I,D,I with one idle cycle between grants.
        reqi(1'b1, 32'h0000_00A0);
        reqd(1'b1, 1'b0, 4'hF, 32'h0000_00B0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            ck("rr_cyc", b0.wbm_cyc_o, 1);
            ck("rr_addr", b0.wbm_addr_o, (k % 2 == 0) ? 32'hB0 : 32'hA0);
            b0.wbm_ack_i = 1'b1;
            #1 ck("rr_ack", {b0.iwbs_ack_o, b0.dwbs_ack_o}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            b0.wbm_ack_i = 1'b0;
            if (k == 3) begin
                reqi(1'b0, 32'h0);
                reqd(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
            #1 ck("rr_bubble", b0.wbm_cyc_o, 0);
        end

        // Data write where ack and err coincide: err wins.
        reqd(1'b1, 1'b1, 4'h3, 32'h0000_0040, 32'hDEAD_BEEF);
        tick(); #1;
        ck("dwr_we_sel", {b0.wbm_we_o, b0.wbm_sel_o}, 5'h13);
        ck("dwr_dat", b0.wbm_dat_o, 32'hDEAD_BEEF);
        b0.wbm_ack_i = 1'b1; b0.wbm_err_i = 1'b1;
        #1 ck("dwr_ack_err", {b0.dwbs_ack_o, b0.dwbs_err_o}, 2'b01);
        tick();
        b0.wbm_ack_i = 1'b0; b0.wbm_err_i = 1'b0;
        reqd(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;

        // Timeout of 4 on an unanswered I cycle, D pending behind it.
        reqi(1'b1, 32'h0000_0100);
        reqd(1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
        tick(); #1;
        ck("tmo_c1_cyc", b0.wbm_cyc_o, 1);
        ck("tmo_c1_addr", b0.wbm_addr_o, 32'h100);
        ck("tmo_c1_err", b0.iwbs_err_o, 0);
        tick(); #1 ck("tmo_c2_err", b0.iwbs_err_o, 0);
        tick(); #1 ck("tmo_c3_err", b0.iwbs_err_o, 0);
        tick(); #1;
        ck("tmo_c4_err", {b0.iwbs_err_o, b0.dwbs_err_o}, 2'b10);
        ck("tmo_c4_cyc", {b0.wbm_cyc_o, b0.wbm_stb_o}, 2'b00);
        tick();
        reqi(1'b0, 32'h0);
        #1 ck("tmo_idle", {b0.wbm_cyc_o, b0.iwbs_err_o}, 2'b00);
        tick(); #1;
        ck("tmo_next_d_cyc", b0.wbm_cyc_o, 1);
        ck("tmo_next_d_addr", b0.wbm_addr_o, 32'h200);
        b0.wbm_ack_i = 1'b1;
        #1 ck("tmo_next_d_ack", b0.dwbs_ack_o, 1);
        tick();
        b0.wbm_ack_i = 1'b0;
        reqd(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;

        // D aborts after two unanswered cycles; late ack in idle is dropped.
        reqd(1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
        tick(); #1 ck("abt_c1_addr", b0.wbm_addr_o, 32'h300);
        reqi(1'b1, 32'h0000_0400);
        tick(); #1 ck("abt_c2_addr", b0.wbm_addr_o, 32'h300);
        tick();
        b0.dwbs_cyc_i = 1'b0; b0.dwbs_stb_i = 1'b0;
        #1;
        ck("abt_rsp", {b0.dwbs_ack_o, b0.dwbs_err_o}, 2'b00);
        ck("abt_cyc", b0.wbm_cyc_o, 0);
        tick();
        b0.wbm_ack_i = 1'b1;
        #1;
        ck("late_ack_rsp", {b0.iwbs_ack_o, b0.iwbs_err_o, b0.dwbs_ack_o, b0.dwbs_err_o}, 0);
        ck("late_ack_cyc", b0.wbm_cyc_o, 0);
        tick();
        b0.wbm_ack_i = 1'b0;
        #1;
        ck("abt_next_i_cyc", b0.wbm_cyc_o, 1);
        ck("abt_next_i_addr", b0.wbm_addr_o, 32'h400);
        b0.wbm_ack_i = 1'b1;
        #1 ck("abt_next_i_ack", b0.iwbs_ack_o, 1);
        tick();
        b0.wbm_ack_i = 1'b0;
        reqi(1'b0, 32'h0);
        #1;

        // Timeout disabled: I stays granted well past counter saturation.
        b1.iwbs_cyc_i = 1'b1; b1.iwbs_stb_i = 1'b1; b1.iwbs_addr_i = 32'h500;
        repeat (300) begin
            tick(); #1;
            if (b1.iwbs_err_o !== 1'b0) e1++;
        end
        ck("t0_err_count", e1, 0);
        ck("t0_cyc", b1.wbm_cyc_o, 1);
        ck("t0_addr", b1.wbm_addr_o, 32'h500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
